load_store_unit: RTL and testbench

- Consumes the decoder's memory-control outputs: is_load, mem_write, load_type, load_unsigned, store_type.
- Uses those signals plus the ALU address and rs2 data to run one data-memory transaction over a req/gnt/rvalid bus.
- Returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline while a transaction is outstanding.
- Sits between the execute stage and data memory.

---
 rtl/load_store_unit_pkg.sv | 67 ++++++
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings, access sizes and small decode helpers.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [XLEN/8-1:0] be_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // SZ_NONE marks a funct3 that has no legal access of that kind.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  function automatic size_t load_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      LB, LBU: sz = SZ_BYTE;
      LH, LHU: sz = SZ_HALF;
      LW:      sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic size_t store_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      SB:      sz = SZ_BYTE;
      SH:      sz = SZ_HALF;
      SW:      sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  // True when the access size is legal and naturally aligned at this offset.
  function automatic logic size_ok(input size_t sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: one request with req/gnt handshake, read data returned
// later with rvalid.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic  req;
  logic  we;
  word_t addr;
  be_t   be;
  word_t wdata;
  logic  gnt;
  logic  rvalid;
  word_t rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Purely combinational lane logic: store byte enables / lane replication and
// legality checks on the incoming request, and load extraction on the
// returned bus word using the registered access attributes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0] st_type,
  input  logic [1:0] offset,
  input  word_t      st_wdata,
  input  logic [2:0] ld_type,
  output be_t        st_be,
  output word_t      st_data,
  output logic       st_legal,
  output logic       ld_legal,
  input  logic [2:0] x_type,
  input  logic       x_unsigned,
  input  logic [1:0] x_offset,
  input  word_t      x_rdata,
  output word_t      x_data
);

  size_t st_sz;
  size_t x_sz;
  word_t shifted;

  // Store path: enables shifted to the byte offset, data replicated on all lanes.
  always_comb begin
    st_sz    = store_size(st_type);
    st_legal = size_ok(st_sz, offset);
    ld_legal = size_ok(load_size(ld_type), offset);
    st_be    = '0;
    st_data  = st_wdata;
    case (st_sz)
      SZ_BYTE: begin
        st_be   = be_t'(4'b0001 << offset);
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = be_t'(4'b0011 << offset);
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = '0;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    x_sz    = load_size(x_type);
    shifted = x_rdata >> {x_offset, 3'b000};
    case (x_sz)
      SZ_BYTE: x_data = x_unsigned ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: x_data = x_unsigned ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: x_data = x_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction per accepted
// instruction and stalls the pipeline until it completes, faults or times out.
//
// state | meaning
// IDLE  | waiting for a memory instruction; accept cycle decided here
// REQ   | mem_req asserted with stable attributes until mem_gnt
// RESP  | load granted, waiting for mem_rvalid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_load,
  input  logic       mem_write,
  input  logic [2:0] load_type,
  input  logic       load_unsigned,
  input  logic [2:0] store_type,
  input  word_t      addr,
  input  word_t      wdata,
  output logic       stall,
  output logic       done,
  output word_t      rdata,
  output logic       misaligned,
  output logic       bus_err,
  load_store_unit_if.master mem
);

  // The down-counter is loaded with TIMEOUT_CYCLES-1 on state entry, so the
  // state is occupied for exactly TIMEOUT_CYCLES cycles before giving up.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  word_t      addr_q;
  word_t      wdata_q;
  be_t        be_q;
  logic       we_q;
  logic [2:0] ltype_q;
  logic       lunsigned_q;
  logic [1:0] off_q;

  logic  done_q, mis_q, err_q;
  word_t rdata_q;

  logic  done_d, mis_d, err_d, rd_load, req_c;
  logic  accept, legal, timeout;

  be_t   st_be;
  word_t st_data;
  logic  st_legal, ld_legal;
  word_t ld_data;

  lsu_align u_align (
    .st_type    (store_type),
    .offset     (addr[1:0]),
    .st_wdata   (wdata),
    .ld_type    (load_type),
    .st_be      (st_be),
    .st_data    (st_data),
    .st_legal   (st_legal),
    .ld_legal   (ld_legal),
    .x_type     (ltype_q),
    .x_unsigned (lunsigned_q),
    .x_offset   (off_q),
    .x_rdata    (mem.rdata),
    .x_data     (ld_data)
  );

  // A held instruction must not relaunch in its own completion cycle; rst_n
  // gating keeps stall low while reset is asserted.
  assign accept  = rst_n && (state_q == IDLE) && start && (is_load || mem_write)
                   && !done_q && !mis_q && !err_q;
  assign legal   = is_load ? ld_legal : st_legal;
  assign timeout = TMO_EN && (state_q != IDLE) && (cnt_q == '0);

  // Next-state, bus request and completion decode.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) state_d = REQ;
          else       mis_d   = 1'b1;
        end
      end
      REQ: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          req_c = 1'b1;
          if (mem.gnt) begin
            if (we_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (mem.rvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rd_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Timeout counter: reload on every state change, count down while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cnt_q <= '0;
    else if (state_d != state_q)                 cnt_q <= CNT_LOAD;
    else if (state_q != IDLE && cnt_q != '0)     cnt_q <= cnt_q - CW'(1);
  end

  // Capture the access attributes when a legal request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      ltype_q     <= '0;
      lunsigned_q <= 1'b0;
      off_q       <= '0;
    end else if (accept && legal) begin
      addr_q      <= {addr[31:2], 2'b00};
      wdata_q     <= is_load ? '0 : st_data;
      be_q        <= is_load ? '1 : st_be;
      we_q        <= !is_load;
      ltype_q     <= load_type;
      lunsigned_q <= load_unsigned;
      off_q       <= addr[1:0];
    end
  end

  // One-cycle status pulses, registered so they land after the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      mis_q  <= mis_d;
      err_q  <= err_d;
    end
  end

  // Load result holds until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_q <= '0;
    else if (rd_load) rdata_q <= ld_data;
  end

  assign stall      = accept || (state_q != IDLE);
  assign done       = done_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign rdata      = rdata_q;

  assign mem.req   = req_c;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.be    = be_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-abort sequence and
// randomized transactions against a behavioural model.
module tb_load_store_unit;

  localparam int T      = 4;
  localparam int O_DONE = 0;
  localparam int O_MIS  = 1;
  localparam int O_ERR  = 2;
  localparam int NEVER  = 255;

  typedef struct {
    bit          is_ld;
    bit          wr;
    logic [2:0]  ty;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          gnt_dly;
    int          rv_dly;
    int          exp_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          out;
    int          stall_n;
    int          req_n;
    bit          granted;
    bit          unstable;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, mem_write, load_unsigned;
  logic [2:0]  load_type, store_type;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if mem_bus();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .is_load       (is_load),
    .mem_write     (mem_write),
    .load_type     (load_type),
    .load_unsigned (load_unsigned),
    .store_type    (store_type),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .done          (done),
    .rdata         (rdata),
    .misaligned    (misaligned),
    .bus_err       (bus_err),
    .mem           (mem_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit is_ld, bit wr, logic [2:0] ty, bit uns, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, int g, int r, int out,
                              logic [3:0] ebe, logic [31:0] ewd, logic [31:0] erd, int est);
    vec_t v;
    v.is_ld = is_ld; v.wr = wr; v.ty = ty; v.uns = uns; v.addr = a; v.wdata = wd; v.rd = rd;
    v.gnt_dly = g; v.rv_dly = r; v.exp_out = out; v.exp_be = ebe; v.exp_wd = ewd;
    v.exp_rd = erd; v.exp_stall = est;
    return v;
  endfunction

  // Behavioural model: outcome, cycle count and data from the access rules.
  function automatic vec_t ref_model(vec_t v, logic [31:0] prev);
    int          size, off;
    logic [3:0]  bm;
    logic [31:0] mask, val;
    off  = int'(v.addr[1:0]);
    size = 0;
    if (v.is_ld) begin
      case (v.ty)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
    end else begin
      case (v.ty)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: size = 0;
      endcase
    end
    v.exp_rd = prev; v.exp_be = '0; v.exp_wd = '0;
    if (size == 0 || (off % size) != 0) begin
      v.exp_out = O_MIS; v.exp_stall = 1;
    end else if (v.gnt_dly >= T - 1) begin
      v.exp_out = O_ERR; v.exp_stall = 1 + T;
    end else if (!v.is_ld) begin
      v.exp_out   = O_DONE;
      v.exp_stall = 2 + v.gnt_dly;
      bm          = 4'((1 << size) - 1);
      v.exp_be    = bm << off;
      if (size == 1)      v.exp_wd = {24'b0, v.wdata[7:0]} * 32'h0101_0101;
      else if (size == 2) v.exp_wd = {16'b0, v.wdata[15:0]} * 32'h0001_0001;
      else                v.exp_wd = v.wdata;
    end else if (v.rv_dly >= T - 1) begin
      v.exp_out = O_ERR; v.exp_stall = 1 + (v.gnt_dly + 1) + T;
    end else begin
      v.exp_out   = O_DONE;
      v.exp_stall = 3 + v.gnt_dly + v.rv_dly;
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
      val  = (v.rd >> (8 * off)) & mask;
      if (!v.uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
      v.exp_rd = val;
    end
    return v;
  endfunction

  // Drives one held instruction plus a memory responder until a pulse appears.
  task automatic run_txn(input vec_t v, output res_t r);
    int cyc = 0, reqc = 0, k = 0;
    bit fin = 0;
    r.out = -1; r.stall_n = 0; r.req_n = 0; r.granted = 0; r.unstable = 0;
    r.a = '0; r.be = '0; r.wd = '0; r.we = 1'b0; r.rd = '0;
    while (!fin && cyc < 60) begin
      @(posedge clk); #1;
      start = 1'b1; is_load = v.is_ld; mem_write = v.wr;
      load_type = v.ty; store_type = v.ty; load_unsigned = v.uns;
      addr = v.addr; wdata = v.wdata;
      mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = $urandom;
      if (r.granted) begin
        k++;
        if (k == v.rv_dly + 1) begin
          mem_bus.rvalid = 1'b1; mem_bus.rdata = v.rd;
        end
      end
      if (mem_bus.req) begin
        if (reqc == 0) begin
          r.a = mem_bus.addr; r.be = mem_bus.be; r.wd = mem_bus.wdata; r.we = mem_bus.we;
        end else if (r.a !== mem_bus.addr || r.be !== mem_bus.be ||
                     r.wd !== mem_bus.wdata || r.we !== mem_bus.we) begin
          r.unstable = 1'b1;
        end
        if (reqc >= v.gnt_dly) begin
          mem_bus.gnt = 1'b1; r.granted = 1'b1;
          if (v.is_ld) begin
            mem_bus.rvalid = 1'b1; mem_bus.rdata = ~v.rd;
          end
        end
        reqc++;
      end
      @(negedge clk);
      if (stall) r.stall_n++;
      if (mem_bus.req) r.req_n++;
      if (done || misaligned || bus_err) begin
        r.out = done ? O_DONE : (misaligned ? O_MIS : O_ERR);
        if ((32'(done) + 32'(misaligned) + 32'(bus_err)) != 1) r.out = 9;
        r.rd = rdata;
        fin  = 1'b1;
      end
      cyc++;
    end
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
  endtask

  task automatic check_txn(input vec_t v, input string tag);
    res_t r;
    run_txn(v, r);
    chk({tag, " outcome"}, 32'(r.out), 32'(v.exp_out));
    chk({tag, " stall_cycles"}, 32'(r.stall_n), 32'(v.exp_stall));
    chk({tag, " rdata"}, r.rd, v.exp_rd);
    chk({tag, " bus_stable"}, 32'(r.unstable), 32'd0);
    if (v.exp_out == O_MIS) chk({tag, " no_req"}, 32'(r.req_n), 32'd0);
    if (r.granted) begin
      chk({tag, " mem_addr"}, r.a, v.addr & 32'hFFFF_FFFC);
      chk({tag, " mem_we"}, 32'(r.we), 32'(!v.is_ld));
      if (!v.is_ld) begin
        chk({tag, " mem_be"}, 32'(r.be), 32'(v.exp_be));
        chk({tag, " mem_wdata"}, r.wd, v.exp_wd);
      end
    end
  endtask

  vec_t        tbl [17];
  vec_t        v;
  logic [31:0] last_rd;
  bit          seen_done, rd_moved;

  initial begin
    // is_ld wr ty uns addr wdata rd gnt rv | out be wdata rdata stall
    tbl[0]  = mk(0,1,3'b010,0,32'h104,32'hDEADBEEF,0,1,0,         O_DONE,4'hF,32'hDEADBEEF,32'h0,3);
    tbl[1]  = mk(0,1,3'b000,0,32'h203,32'h000000A5,0,0,0,         O_DONE,4'h8,32'hA5A5A5A5,32'h0,2);
    tbl[2]  = mk(1,0,3'b000,0,32'h302,0,32'h12F03456,0,0,         O_DONE,0,0,32'hFFFFFFF0,3);
    tbl[3]  = mk(1,0,3'b100,1,32'h302,0,32'h12F03456,0,0,         O_DONE,0,0,32'h000000F0,3);
    tbl[4]  = mk(1,0,3'b001,0,32'h302,0,32'h12F03456,0,0,         O_DONE,0,0,32'h000012F0,3);
    tbl[5]  = mk(1,0,3'b010,0,32'h401,0,0,0,0,                    O_MIS,0,0,32'h000012F0,1);
    tbl[6]  = mk(0,1,3'b001,0,32'h403,32'h1234,0,0,0,             O_MIS,0,0,32'h000012F0,1);
    tbl[7]  = mk(1,0,3'b010,0,32'h500,0,32'h0,0,NEVER,            O_ERR,0,0,32'h000012F0,6);
    tbl[8]  = mk(1,0,3'b010,0,32'h600,0,32'hCAFEF00D,2,1,         O_DONE,0,0,32'hCAFEF00D,6);
    tbl[9]  = mk(0,1,3'b001,0,32'h702,32'h1234BEEF,0,0,0,         O_DONE,4'hC,32'hBEEFBEEF,32'hCAFEF00D,2);
    tbl[10] = mk(0,1,3'b010,0,32'h710,32'h1,0,NEVER,0,            O_ERR,0,0,32'hCAFEF00D,5);
    tbl[11] = mk(0,1,3'b011,0,32'h800,32'h1,0,0,0,                O_MIS,0,0,32'hCAFEF00D,1);
    tbl[12] = mk(1,0,3'b011,0,32'h800,0,0,0,0,                    O_MIS,0,0,32'hCAFEF00D,1);
    tbl[13] = mk(1,0,3'b101,1,32'h906,0,32'h80010000,1,2,         O_DONE,0,0,32'h00008001,6);
    tbl[14] = mk(1,0,3'b001,0,32'h906,0,32'h80010000,0,0,         O_DONE,0,0,32'hFFFF8001,3);
    tbl[15] = mk(1,1,3'b000,0,32'hA01,32'h77,32'h00008000,0,0,    O_DONE,0,0,32'hFFFFFF80,3);
    tbl[16] = mk(1,0,3'b101,1,32'h907,0,0,0,0,                    O_MIS,0,0,32'hFFFFFF80,1);

    // Reset held with a live request on the inputs: everything must stay 0.
    rst_n = 1'b0; start = 1'b1; is_load = 1'b1; mem_write = 1'b0; load_type = 3'b010;
    store_type = 3'b010; load_unsigned = 1'b0; addr = 32'h100; wdata = 32'h0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'h0;
    #23;
    chk("reset stall", 32'(stall), 0);
    chk("reset done", 32'(done), 0);
    chk("reset misaligned", 32'(misaligned), 0);
    chk("reset bus_err", 32'(bus_err), 0);
    chk("reset rdata", rdata, 0);
    chk("reset mem_req", 32'(mem_bus.req), 0);
    chk("reset mem_be", 32'(mem_bus.be), 0);
    chk("reset mem_addr", mem_bus.addr, 0);
    start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    foreach (tbl[i]) check_txn(tbl[i], $sformatf("t%0d", i));

    // Reset while a load sits in RESP: abandon it and ignore the late rvalid.
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; mem_write = 1'b0; load_type = 3'b010; addr = 32'hB00;
    @(posedge clk); #1; mem_bus.gnt = 1'b1;
    @(posedge clk); #1; mem_bus.gnt = 1'b0;
    @(negedge clk);
    chk("rst_resp pre stall", 32'(stall), 1);
    rst_n = 1'b0; #1;
    chk("rst_resp mem_req", 32'(mem_bus.req), 0);
    chk("rst_resp stall", 32'(stall), 0);
    chk("rst_resp done", 32'(done), 0);
    chk("rst_resp rdata", rdata, 0);
    start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hFFFF_FFFF;
    seen_done = 0; rd_moved = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) seen_done = 1;
      if (rdata !== 32'h0) rd_moved = 1;
      @(posedge clk); #1; if (c == 1) mem_bus.rvalid = 1'b0;
    end
    mem_bus.rvalid = 1'b0;
    chk("rst_resp late done", 32'(seen_done), 0);
    chk("rst_resp late rdata", 32'(rd_moved), 0);
    last_rd = 32'h0;

    // Randomized transactions with occasional idle / no-op cycles.
    for (int n = 0; n < 150; n++) begin
      int kind;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        start = $urandom_range(0, 1); is_load = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk($sformatf("r%0d idle stall", n), 32'(stall), 0);
      end
      kind       = $urandom_range(0, 2);
      v.is_ld    = (kind != 1);
      v.wr       = (kind != 0);
      v.ty       = 3'($urandom_range(0, 7));
      v.uns      = $urandom_range(0, 1);
      v.addr     = $urandom;
      v.wdata    = $urandom;
      v.rd       = $urandom;
      v.gnt_dly  = $urandom_range(0, 4);
      v.rv_dly   = $urandom_range(0, 4);
      v = ref_model(v, last_rd);
      last_rd = v.exp_rd;
      check_txn(v, $sformatf("r%0d", n));
    end

    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
